// File: rtl/xorshift128_range_gen.sv
// ---------------------------------------------------------------------------
// xorshift128_range_gen
//
// Pseudo-random number source for the whack-a-mole game core. Four WIDTH-bit
// xorshift128 state words produce a raw value, and bounded rejection sampling
// turns it into a value in [0, range-1]. Requests and results use valid/ready
// handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   seed_load  load seed_in this cycle (honoured only while idle)
//   seed_in    {x,y,z,w} seed; an all-zero seed selects INIT_SEED instead
//   req_valid  range request valid
//   req_ready  request accepted when req_valid && req_ready
//   req_range  exclusive upper bound of the requested result
//   rnd_valid  bounded result valid
//   rnd_ready  consumer accepts the result
//   rnd_data   bounded result
//   rnd_raw    w word of the state that produced rnd_data
//   busy       high whenever the generator is not idle
// ---------------------------------------------------------------------------
module xorshift128_range_gen #(
    parameter int           WIDTH     = 32,
    parameter int           OUT_W     = 4,
    parameter int           SH_A      = 11,
    parameter int           SH_B      = 8,
    parameter int           SH_C      = 19,
    parameter int           MAX_TRIES = 4,
    parameter bit           FREE_RUN  = 1'b1,
    parameter logic [127:0] INIT_SEED = 128'h12345678_23456789_34567890_456789AB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_load,
    input  logic [4*WIDTH-1:0] seed_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OUT_W-1:0]   req_range,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic [OUT_W-1:0]   rnd_data,
    output logic [WIDTH-1:0]   rnd_raw,
    output logic               busy
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    // Each 32-bit field of INIT_SEED is zero-extended into a WIDTH-bit word.
    function automatic logic [4*WIDTH-1:0] expand_seed(input logic [127:0] s);
        logic [4*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'(s[i*32 +: 32]);
        end
        return r;
    endfunction

    localparam logic [4*WIDTH-1:0] INIT_STATE = expand_seed(INIT_SEED);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_VALID
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, y_q, z_q, w_q;
    logic [WIDTH-1:0]   x_d, y_d, z_d, w_d;
    logic [OUT_W-1:0]   range_q, range_d;
    logic [TRY_W-1:0]   try_cnt_q, try_cnt_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic [OUT_W-1:0]   rnd_data_q, rnd_data_d;
    logic [WIDTH-1:0]   rnd_raw_q, rnd_raw_d;

    logic [WIDTH-1:0]   t;
    logic [WIDTH-1:0]   next_w;
    logic [OUT_W-1:0]   mask;
    logic [OUT_W-1:0]   cand;
    logic [4*WIDTH-1:0] load_val;

    // One xorshift128 step, and the candidate drawn from the stepped w word.
    // The mask is range-1 with every bit below its MSB set, i.e. the
    // smallest 2^k-1 covering all legal results.
    always_comb begin
        t      = x_q ^ (x_q << SH_A);
        next_w = w_q ^ (w_q >> SH_C) ^ t ^ (t >> SH_B);
        mask   = range_q - 1'b1;
        for (int i = 1; i < OUT_W; i = i * 2) begin
            mask = mask | (mask >> i);
        end
        if (range_q <= OUT_W'(1)) begin
            mask = '0;
        end
        cand     = next_w[OUT_W-1:0] & mask;
        load_val = (seed_in == '0) ? INIT_STATE : seed_in;
    end

    // Next-state logic for the request/generate/hold sequence.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        w_d         = w_q;
        range_d     = range_q;
        try_cnt_d   = try_cnt_q;
        rnd_valid_d = rnd_valid_q;
        rnd_data_d  = rnd_data_q;
        rnd_raw_d   = rnd_raw_q;

        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    {x_d, y_d, z_d, w_d} = load_val;
                end else begin
                    if (FREE_RUN) begin
                        {x_d, y_d, z_d, w_d} = {y_q, z_q, w_q, next_w};
                    end
                    if (req_valid) begin
                        range_d   = req_range;
                        try_cnt_d = '0;
                        state_d   = ST_GEN;
                    end
                end
            end

            ST_GEN: begin
                {x_d, y_d, z_d, w_d} = {y_q, z_q, w_q, next_w};
                // On the last permitted try the out-of-range candidate is
                // folded down by range; mask < 2*range keeps it in bounds.
                if (range_q <= OUT_W'(1)) begin
                    rnd_data_d  = '0;
                    rnd_raw_d   = next_w;
                    rnd_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end else if (cand < range_q) begin
                    rnd_data_d  = cand;
                    rnd_raw_d   = next_w;
                    rnd_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end else if (try_cnt_q == LAST_TRY) begin
                    rnd_data_d  = cand - range_q;
                    rnd_raw_d   = next_w;
                    rnd_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end else begin
                    try_cnt_d = try_cnt_q + 1'b1;
                end
            end

            ST_VALID: begin
                if (rnd_ready) begin
                    rnd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= ST_IDLE;
            {x_q, y_q, z_q, w_q} <= INIT_STATE;
            range_q              <= '0;
            try_cnt_q            <= '0;
            rnd_valid_q          <= 1'b0;
            rnd_data_q           <= '0;
            rnd_raw_q            <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            w_q         <= w_d;
            range_q     <= range_d;
            try_cnt_q   <= try_cnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_raw_q   <= rnd_raw_d;
        end
    end

    // A same-cycle seed load wins over a request, so the request is refused.
    assign req_ready = (state_q == ST_IDLE) && !seed_load;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_raw   = rnd_raw_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/xorshift128_range_gen.md
Name: xorshift128_range_gen

Overview:
Parametrised second-generation PRNG for the whack-a-mole game core. It uses xorshift128 with four WIDTH-bit state words and configurable shift triple. It delivers uniformly distributed values in [0, range-1] through a valid/ready request/response handshake, using bounded rejection sampling. Consumers are mole-position and delay-timer selection. Runtime reseeding has all-zero protection. Optional free-running stepping lets player timing add entropy.

Parameters:
WIDTH, 32, state word and raw output width (32 or 64)
OUT_W, 4, width of range request and bounded result
SH_A, 11, left shift applied to t
SH_B, 8, right shift applied to t
SH_C, 19, right shift applied to w
MAX_TRIES, 4, rejected candidates before fallback correction (>=1)
FREE_RUN, 1, 1 = state steps every IDLE cycle; 0 = steps only while generating
INIT_SEED, 128'h12345678_23456789_34567890_456789AB, default {x,y,z,w}; low WIDTH bits of each 32-bit field are zero-extended when WIDTH=64

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
seed_load  in  1  load seed_in this cycle (IDLE only)
seed_in  in  4*WIDTH  {x,y,z,w} seed
req_valid  in  1  range request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_range  in  OUT_W  exclusive upper bound of result
rnd_valid  out  1  result valid
rnd_ready  in  1  consumer accepts result
rnd_data  out  OUT_W  bounded result
rnd_raw  out  WIDTH  w word of the state that produced rnd_data
busy  out  1  state != IDLE

Behaviour:
- Step function: t = x ^ (x<<SH_A). Next state: x'=y, y'=z, z'=w, w' = w ^ (w>>SH_C) ^ t ^ (t>>SH_B). All values are truncated to WIDTH.
- Reset: state <= INIT_SEED. FSM goes to IDLE. rnd_valid=0, rnd_data=0, rnd_raw=0, busy=0. req_ready=1 in the first cycle after reset. Reset overrides everything, including mid-GEN and mid-VALID. Any pending result is dropped.
- FSM states: IDLE, GEN, VALID.
- IDLE:
  - req_ready = !seed_load.
  - When seed_load=1: the state loads seed_in. If seed_in is all-zero, INIT_SEED is loaded instead. seed_load takes priority over a same-cycle request.
  - Otherwise, with FREE_RUN=1, the state steps every cycle.
  - When a request is accepted: latch req_range into range_q, clear try_cnt, go to GEN.
  - seed_load is ignored outside IDLE.
- GEN (one step per cycle):
  - mask = smallest 2^k-1 >= range_q-1 (mask=0 for range_q<=1). cand = w'[OUT_W-1:0] & mask.
  - range_q==0 or 1: result is 0, accepted on the first step.
  - cand < range_q: accept.
  - Else if try_cnt==MAX_TRIES-1: accept cand-range_q. This is always < range_q because mask < 2*range_q.
  - Else: try_cnt++ and stay in GEN.
  - On accept: rnd_data <= result, rnd_raw <= w', rnd_valid <= 1, go to VALID.
- Latency: acceptance at edge N gives rnd_valid high after edge N+1 in the best case. Worst case is edge N+MAX_TRIES.
- VALID:
  - rnd_data and rnd_raw are held stable and rnd_valid stays 1 until rnd_ready=1. The state does not step in VALID.
  - On a handshake: rnd_valid <= 0, go to IDLE.
  - req_ready=0 in VALID and GEN, so there is no back-to-back overlap. The next request can be accepted the cycle after the rnd handshake.
- Power-of-two range: when range_q is a power of two, mask=range_q-1, so no rejection ever occurs.
- Width rules: range_q up to 2^OUT_W-1. Shifts are logical and zero-fill.

Test Plan:
1. FREE_RUN=0, reset, request range=6, rnd_ready=1 -> rnd_data in 0..5. rnd_raw matches the golden xorshift128 first step from INIT_SEED. rnd_valid rises exactly 1 cycle after acceptance when the first candidate is <6.
2. Range=1 and range=0 requests -> rnd_data=0 after exactly 1 GEN cycle. busy returns to 0 after the handshake.
3. MAX_TRIES=1, range=5 (mask=7), seed chosen so the first w'[2:0]=6 -> rnd_data=1 (fallback 6-5) after 1 GEN cycle.
4. seed_load with seed_in=0, then request range=16 -> result equals the INIT_SEED-derived value. Asserting seed_load and req_valid in the same cycle -> req_ready=0 and the seed is loaded.
5. Hold rnd_ready=0 for 10 cycles in VALID -> rnd_data and rnd_raw stay constant and the state does not advance. The next request yields the golden second-step value.
6. Assert rst mid-GEN (range=7) -> the next cycle shows rnd_valid=0, busy=0, req_ready=1, and the state equals INIT_SEED. Then 1000 requests with range=10 -> all results <10 and each value appears 70-130 times.
